// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch-stage bus joining the PC sequencer, instruction memory and decode
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        fault;
    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, fault,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, fault,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: stall-aware PC sequencer issuing one fetch per PC and buffering the word for decode
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          MAX_WAIT = 15
) (
    input logic          clk,
    input logic          reset,
    fetch_sequencer_if.master bus
);
    localparam int W = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] WAIT_LAST = W'(MAX_WAIT);
    typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [W-1:0] wait_q, wait_d;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        wait_d  = wait_q;
        if (state_q != FAULT && bus.redirect) begin
            pc_d    = {bus.redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
            wait_d  = '0;
            state_d = FETCH;
        end else if (state_q == FETCH) begin
            if (bus.imem_ack) begin
                instr_d = bus.imem_rdata;
                valid_d = 1'b1;
                wait_d  = '0;
                state_d = HOLD;
            end else if (wait_q == WAIT_LAST) begin
                fault_d = 1'b1;
                valid_d = 1'b0;
                state_d = FAULT;
            end else begin
                wait_d = wait_q + W'(1);
            end
        end else if (state_q == HOLD && bus.instr_ready) begin
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b0;
            state_d = FETCH;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end
    assign bus.imem_req    = state_q == FETCH;
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random and directed stimulus against a transaction-level model with a word scoreboard
module tb_fetch_sequencer;
    localparam int MAX_WAIT = 15;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    fetch_sequencer_if bus ();
    fetch_sequencer #(.RESET_PC(32'h0000_3000), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    typedef struct {logic [31:0] pc; logic [31:0] word;} exp_t;
    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    logic [31:0] m_pc, m_word;
    bit m_have, m_fault;
    int m_miss;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_pc = 32'h0000_3000;
        m_word = '0;
        m_have = 0;
        m_fault = 0;
        m_miss = 0;
    endtask
    task automatic step(bit r, bit ack, logic [31:0] rd, bit rdy, bit redir, logic [31:0] rpc);
        @(negedge clk);
        chk("pc", bus.pc, m_pc);
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("imem_req", 32'(bus.imem_req), 32'(!m_have && !m_fault));
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_have));
        chk("fault", 32'(bus.fault), 32'(m_fault));
        chk("instr", bus.instr, m_word);
        reset = r;
        bus.imem_ack = ack;
        bus.imem_rdata = rd;
        bus.instr_ready = rdy;
        bus.redirect = redir;
        bus.redirect_pc = rpc;
        if (r) model_reset();
        else if (m_fault) begin
        end else if (redir) begin
            m_pc = {rpc[31:2], 2'b00};
            m_have = 0;
            m_miss = 0;
        end else if (m_have) begin
            if (rdy) begin
                m_pc = m_pc + 32'd4;
                m_have = 0;
            end
        end else if (ack) begin
            m_have = 1;
            m_word = rd;
            m_miss = 0;
            sb.push_back('{m_pc, rd});
        end else begin
            m_miss++;
            if (m_miss > MAX_WAIT) m_fault = 1;
        end
    endtask
    task automatic idle();
        step(0, 0, 32'h0, 0, 0, 32'h0);
    endtask
    bit prev_v = 0;
    always @(negedge clk) begin
        if (bus.instr_valid === 1'b1 && !prev_v) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: word %h presented at pc %h, none expected", bus.instr, bus.pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", bus.instr, e.word);
                chk("sb_pc", bus.pc, e.pc);
            end
        end
        prev_v = bus.instr_valid === 1'b1;
    end
    initial begin
        bus.imem_ack = 0;
        bus.imem_rdata = '0;
        bus.instr_ready = 0;
        bus.redirect = 0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        model_reset();
        repeat (6) step(0, 1, $urandom, 1, 0, 0);
        if (m_have) step(0, 0, 0, 1, 0, 0);
        step(0, 1, 32'h2402_000A, 0, 0, 0);
        repeat (5) step(0, 1'($urandom % 2), $urandom, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle();
        if (!m_have) step(0, 1, $urandom, 0, 0, 0);
        step(0, 0, 0, 1, 1, 32'h0000_3043);
        idle();
        step(0, 1, 32'hDEAD_BEEF, 0, 1, 32'h0000_5000);
        idle();
        repeat (16) idle();
        step(0, 0, 0, 1, 1, 32'h0000_0100);
        repeat (3) step(0, 1, $urandom, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle();
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        step(0, 1, $urandom, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle();
        for (int p = 0; p < 4; p++) begin
            int ack_pct;
            ack_pct = (p == 0) ? 90 : (p == 1) ? 50 : (p == 2) ? 20 : 60;
            for (int i = 0; i < 1000; i++)
                step(($urandom % 150) == 0, ($urandom % 100) < ack_pct, $urandom,
                     1'($urandom % 2), ($urandom % 16) == 0, $urandom);
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
